uart_rx_sipo: RTL
=================

# uart_rx_sipo

UART receiver stage: serial-in/parallel-out deserializer that consumes the 11-bit frame produced by the transmitter PISO: start 0, 8 data bits LSB first, parity, stop 1. It oversamples the line on `baud_clk` and presents the received byte with parity/framing/overrun status to the host side. It forms the RX half of the UART, directly downstream of the TX line.

## Interface
- `OVERSAMPLE`, 16: `baud_clk` cycles per bit; even, ≥4.
- `PARITY_ODD`, 0: 0 = even parity expected, 1 = odd.
- `baud_clk`  in  1  clock, OVERSAMPLE × bit rate.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `data_rx`  in  1  serial line, idle high.
- `rx_ack`  in  1  host acknowledge; clears `rx_ready` and `overrun_err`.
- `data_out`  out  8  last received byte.
- `rx_ready`  out  1  byte available; level, held until acked.
- `parity_err`  out  1  parity mismatch for the byte in `data_out`.
- `frame_err`  out  1  stop bit sampled 0 for the byte in `data_out`.
- `overrun_err`  out  1  sticky; a frame completed while `rx_ready` was high.
- `active_flag`  out  1  high while a frame is being received.

## Operation
- Reset values: `data_out`=0, `rx_ready`=0, `parity_err`=0, `frame_err`=0, `overrun_err`=0, `active_flag`=0. State is IDLE and all counters are 0.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: sampled line `rx_s`=0 → START. The tick counter clears and the bit counter clears.
- START: at the mid-bit tick (OVERSAMPLE/2 cycles after entry), `rx_s`=1 means a false start → IDLE with no status change. Otherwise → DATA.
- DATA: sample every OVERSAMPLE cycles and shift right into an 8-bit register, LSB first. After 8 samples → PARITY.
- PARITY: sample the bit. Error if the bit ≠ (^data XOR PARITY_ODD).
- STOP: sample the bit and commit on that same cycle.
  - Commit loads `data_out`, `parity_err` and `frame_err`, and sets `rx_ready`.
  - If `rx_ready` was already 1, set `overrun_err` and overwrite `data_out`.
  - Stop=1 → IDLE, so a new start can be detected from the next cycle. Stop=0 → WAIT_HIGH.
- WAIT_HIGH: stays until `rx_s`=1, then → IDLE. A line held low (break) therefore yields exactly one frame_err commit.
- `rx_ack` with no commit that cycle: `rx_ready` and `overrun_err` clear. Commit and `rx_ack` in the same cycle: the commit wins. `rx_ready` stays 1 and no overrun is flagged.
- `active_flag` = state ∉ {IDLE, WAIT_HIGH}.
- Reset mid-frame: immediate return to IDLE with all outputs at reset values. A partial frame is discarded.

## Timing
- Cycle 0 is the first `baud_clk` edge with `rx_s`=0 in IDLE. With H=OVERSAMPLE/2:
  - start check at cycle H;
  - data bit i (0..7) sampled at cycle H+(i+1)·OVERSAMPLE;
  - parity at H+9·OVERSAMPLE;
  - stop at H+10·OVERSAMPLE.
- Commit registers on the stop-sample edge. Outputs are visible from cycle H+10·OVERSAMPLE+1; with OVERSAMPLE=16 that is cycle 169.
- `active_flag` is high from cycle 1 through the stop-sample cycle.
- Back-to-back frames: the next start edge is accepted from the cycle after stop sampling.

## Configuration
- `UART_RX_SYNC_EN` defined: `data_rx` passes through a 2-flop synchronizer, reset value 1, before `rx_s`. This adds 2 cycles to every timing figure above, measured from the pin.
- `UART_RX_SYNC_EN` undefined: `rx_s` = `data_rx` directly. Used for same-domain loopback with the TX PISO.

## Structure
- Shared package `uart_pkg`:
  - state encoding localparams;
  - `FRAME_BITS`=11;
  - `DATA_BITS`=8;
  - the parity function, also used by the transmitter's parity generator.
- One sub-module: `uart_rx_sync`, the 2-flop synchronizer, instantiated only under `UART_RX_SYNC_EN`.

## Test plan
- Send 0xA5 with even parity bit 0 and stop 1 → `data_out`=0xA5, `rx_ready` rises at cycle 169, `parity_err`=0, `frame_err`=0.
- Send 0x3C with a wrong parity bit (1) → `data_out`=0x3C, `parity_err`=1. Then `rx_ack` → `rx_ready`=0.
- Low glitch of 4 cycles in IDLE → false start. Back to IDLE with no `rx_ready` and `active_flag` high for at most H cycles.
- Stop bit 0, then line held low for 40 bit times → exactly one commit with `frame_err`=1. State stays in WAIT_HIGH until the line goes high.
- Two back-to-back frames (0x01, 0xFF) without `rx_ack` → `data_out`=0xFF and `overrun_err`=1. A single `rx_ack` clears both flags.
- Assert `rst_n` low during data bit 4 → all outputs are 0 immediately. A subsequent frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, RX state encoding and parity helper.
package uart_pkg;
  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;
  function automatic logic parity(input logic [DATA_BITS-1:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer for the serial line, resets to the idle-high level.
module uart_rx_sync (
  input  logic baud_clk,
  input  logic rst_n,
  input  logic data_i,
  output logic sync_o
);
  logic [1:0] sync_q;
  always_ff @(posedge baud_clk or negedge rst_n)
    if (!rst_n) sync_q <= 2'b11;
    else sync_q <= {sync_q[0], data_i};
  assign sync_o = sync_q[1];
endmodule

// File: rtl/uart_rx_sipo.sv
// uart_rx_sipo: oversampling UART receiver (start, 8 data LSB first, parity, stop).
// Define UART_RX_SYNC_EN to put a 2-flop synchronizer in front of the line sampler.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 baud_clk,
  input  logic                 rst_n,
  input  logic                 data_rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 active_flag
);
  localparam int H = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  rx_state_t state_q;
  logic [TW-1:0] tick_q;
  logic [BW-1:0] bit_q;
  logic [DATA_BITS-1:0] shift_q, data_q;
  logic par_bad_q, parity_q, frame_q, ready_q, overrun_q;
  logic ready_d, overrun_d;
  logic rx_s, sample, commit;
`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_sync (
    .baud_clk(baud_clk),
    .rst_n   (rst_n),
    .data_i  (data_rx),
    .sync_o  (rx_s)
  );
`else
  assign rx_s = data_rx;
`endif
  // START waits half a bit to land mid-bit; every later bit is a full bit period on.
  assign sample = (state_q == START) ? (tick_q == TW'(H - 1)) : (tick_q == TW'(OVERSAMPLE - 1));
  assign commit = (state_q == STOP) && sample;
  always_comb begin
    ready_d   = commit | (ready_q & ~rx_ack);
    overrun_d = commit ? (overrun_q | (ready_q & ~rx_ack)) : (overrun_q & ~rx_ack);
  end
  always_ff @(posedge baud_clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      parity_q  <= 1'b0;
      frame_q   <= 1'b0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      tick_q    <= (state_q == IDLE || state_q == WAIT_HIGH || sample) ? '0 : tick_q + 1'b1;
      ready_q   <= ready_d;
      overrun_q <= overrun_d;
      if (commit) begin
        data_q   <= shift_q;
        parity_q <= par_bad_q;
        frame_q  <= ~rx_s;
      end
      case (state_q)
        IDLE: if (!rx_s) begin
          state_q <= START;
          bit_q   <= '0;
        end
        START: if (sample) state_q <= rx_s ? IDLE : DATA;
        DATA: if (sample) begin
          shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
          bit_q   <= bit_q + 1'b1;
          if (bit_q == BW'(DATA_BITS - 1)) state_q <= PARITY;
        end
        PARITY: if (sample) begin
          par_bad_q <= rx_s != parity(shift_q, PARITY_ODD);
          state_q   <= STOP;
        end
        STOP: if (sample) state_q <= rx_s ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (rx_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  assign data_out    = data_q;
  assign rx_ready    = ready_q;
  assign parity_err  = parity_q;
  assign frame_err   = frame_q;
  assign overrun_err = overrun_q;
  assign active_flag = (state_q != IDLE) && (state_q != WAIT_HIGH);
endmodule
